// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, one instruction held for decode.
// Redirects flush the held instruction or drain an in-flight request before refetching.
module fetch_unit #(
  parameter int             n        = 16,
  parameter logic [n-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [n-1:0] imem_rdata,
  output logic [n-1:0] instr,
  output logic [2:0]   op,
  output logic [n-1:0] instr_pc,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         redirect,
  input  logic [n-1:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

  state_t       state, state_n;
  logic [n-1:0] pc, pc_n;
  logic [n-1:0] redir_pc, redir_pc_n;
  logic [n-1:0] instr_n, instr_pc_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      redir_pc <= '0;
      instr    <= '0;
      instr_pc <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      redir_pc <= redir_pc_n;
      instr    <= instr_n;
      instr_pc <= instr_pc_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    redir_pc_n = redir_pc;
    instr_n    = instr;
    instr_pc_n = instr_pc;
    case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        if (redirect) begin
          if (imem_ack) begin
            pc_n = redirect_pc;
          end else begin
            redir_pc_n = redirect_pc;
            state_n    = DRAIN;
          end
        end else if (imem_ack) begin
          instr_n    = imem_rdata;
          instr_pc_n = pc;
          pc_n       = pc + n'(1);
          state_n    = HOLD;
        end
      end
      // The in-flight request must complete at its original address; its data is dropped.
      DRAIN: begin
        if (redirect) begin
          redir_pc_n = redirect_pc;
        end
        if (imem_ack) begin
          pc_n    = redirect ? redirect_pc : redir_pc;
          state_n = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_n    = redirect_pc;
          state_n = FETCH;
        end else if (instr_ready) begin
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign imem_req    = (state == FETCH) || (state == DRAIN);
  assign imem_addr   = imem_req ? pc : '0;
  assign instr_valid = (state == HOLD);
  assign op          = instr[n-1:n-3];

endmodule
